// File: rtl/ddr_tx_pkg.sv
// Shared types and helpers for the DDR transmit gearbox: serialiser states,
// the default idle pattern and the sizing of the phase counter.
package ddr_tx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [7:0] DEFAULT_IDLE_PAT = 8'h00;

    // One beat pair is emitted per cycle, so a word spans ratio/2 phases.
    function automatic int phase_width(input int ratio);
        return (ratio / 2 > 1) ? $clog2(ratio / 2) : 1;
    endfunction

endpackage

// File: rtl/ddr_tx_gearbox_if.sv
// Write channel from the framer TX datapath into the gearbox: one wide word
// per transfer on valid & ready, plus a burst-end marker.
interface ddr_tx_gearbox_if #(
    parameter int PAD_WIDTH = 8,
    parameter int RATIO     = 4
);
    logic [RATIO*PAD_WIDTH-1:0] data;
    logic                       last;
    logic                       valid;
    logic                       ready;

    modport master (output data, output last, output valid, input ready);
    modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/ddr_tx_fifo.sv
// Word FIFO between the core and the serialiser. The head word is readable
// combinationally so a pop can load the beat registers on the same edge.
module ddr_tx_fifo #(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    fill
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg,  count_next;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign fill     = count_reg;
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem[rd_ptr_reg];

    // Storage carries no reset: a reset only has to forget the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule

// File: rtl/ddr_tx_gearbox.sv
// DDR transmit gearbox: buffers wide words and serialises them into
// high/low beat pairs on outclock, with idle pattern, oe and underrun flag.
module ddr_tx_gearbox
    import ddr_tx_pkg::*;
#(
    parameter  int                   PAD_WIDTH = 8,
    parameter  int                   RATIO     = 4,
    parameter  int                   DEPTH     = 4,
    parameter  logic [PAD_WIDTH-1:0] IDLE_PAT  = PAD_WIDTH'(DEFAULT_IDLE_PAT),
    localparam int                   FILL_W    = $clog2(DEPTH + 1)
) (
    input  logic                 outclock,
    input  logic                 rst_n,
    ddr_tx_gearbox_if.slave      wr,
    input  logic                 clr_underrun,
    output logic [PAD_WIDTH-1:0] dataout,
    output logic                 oe,
    output logic [FILL_W-1:0]    fill,
    output logic                 underrun
);

    localparam int WORD_W = RATIO * PAD_WIDTH;
    localparam int PAIRS  = RATIO / 2;
    localparam int PH_W   = phase_width(RATIO);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(PAIRS - 1);

    state_t               state_reg, state_next;
    logic [PH_W-1:0]      phase_reg, phase_next, phase_inc;
    logic [PAD_WIDTH-1:0] high_reg, high_next;
    logic [PAD_WIDTH-1:0] low_reg, low_next;
    logic [WORD_W-1:0]    word_reg, word_next;
    logic                 last_reg, last_next;
    logic                 oe_reg, oe_next;
    logic                 underrun_reg, underrun_next;

    logic                 pop;
    logic [WORD_W:0]      fifo_word;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [WORD_W-1:0]    head_data;
    logic                 head_last;

    logic [PAD_WIDTH-1:0] hi_beats [PAIRS];
    logic [PAD_WIDTH-1:0] lo_beats [PAIRS];

    ddr_tx_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (outclock),
        .rst_n     (rst_n),
        .push      (wr.valid),
        .push_data ({wr.last, wr.data}),
        .pop       (pop),
        .pop_data  (fifo_word),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .fill      (fill)
    );

    assign wr.ready  = ~fifo_full;
    assign head_last = fifo_word[WORD_W];
    assign head_data = fifo_word[WORD_W-1:0];
    assign phase_inc = phase_reg + 1'b1;

    // Beat pair p of the held word: even beat on the high phase, odd on low.
    for (genvar gi = 0; gi < PAIRS; gi++) begin : g_pair
        assign hi_beats[gi] = word_reg[(2*gi)*PAD_WIDTH   +: PAD_WIDTH];
        assign lo_beats[gi] = word_reg[(2*gi+1)*PAD_WIDTH +: PAD_WIDTH];
    end

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        high_next     = high_reg;
        low_next      = low_reg;
        word_next     = word_reg;
        last_next     = last_reg;
        underrun_next = underrun_reg;
        pop           = 1'b0;

        if (clr_underrun) begin
            underrun_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                high_next = IDLE_PAT;
                low_next  = IDLE_PAT;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    word_next  = head_data;
                    last_next  = head_last;
                    phase_next = '0;
                    high_next  = head_data[PAD_WIDTH-1:0];
                    low_next   = head_data[2*PAD_WIDTH-1:PAD_WIDTH];
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (phase_reg != LAST_PH) begin
                    phase_next = phase_inc;
                    high_next  = hi_beats[phase_inc];
                    low_next   = lo_beats[phase_inc];
                end else if (!fifo_empty) begin
                    // Word boundary with data waiting: chain straight on,
                    // regardless of burst framing.
                    pop        = 1'b1;
                    word_next  = head_data;
                    last_next  = head_last;
                    phase_next = '0;
                    high_next  = head_data[PAD_WIDTH-1:0];
                    low_next   = head_data[2*PAD_WIDTH-1:PAD_WIDTH];
                end else begin
                    state_next = ST_IDLE;
                    phase_next = '0;
                    high_next  = IDLE_PAT;
                    low_next   = IDLE_PAT;
                    if (!last_reg) begin
                        underrun_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        oe_next = (state_next == ST_RUN);
    end

    always_ff @(posedge outclock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            phase_reg    <= '0;
            high_reg     <= IDLE_PAT;
            low_reg      <= IDLE_PAT;
            word_reg     <= '0;
            last_reg     <= 1'b0;
            oe_reg       <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            high_reg     <= high_next;
            low_reg      <= low_next;
            word_reg     <= word_next;
            last_reg     <= last_next;
            oe_reg       <= oe_next;
            underrun_reg <= underrun_next;
        end
    end

    // Pad mux: the clock level picks which registered beat reaches the pad.
    assign dataout  = outclock ? high_reg : low_reg;
    assign oe       = oe_reg;
    assign underrun = underrun_reg;

endmodule

// File: tb/tb_ddr_tx_gearbox.sv
// Directed bench for ddr_tx_gearbox: single burst, back-to-back, full FIFO,
// underrun flag handling and reset in the middle of a burst.
module tb_ddr_tx_gearbox;

    localparam int PW = 8;
    localparam int R  = 4;
    localparam int D  = 4;

    logic          outclock = 1'b0;
    logic          rst_n    = 1'b0;
    logic          clr_underrun = 1'b0;
    logic [PW-1:0] dataout;
    logic          oe;
    logic [2:0]    fill;
    logic          underrun;

    int tests_run  = 0;
    int fail_count = 0;

    logic [31:0] words [$];
    logic [7:0]  exp_hi [$];
    logic [7:0]  exp_lo [$];
    bit          saw_full;

    ddr_tx_gearbox_if #(.PAD_WIDTH(PW), .RATIO(R)) wr_bus ();

    ddr_tx_gearbox #(
        .PAD_WIDTH (PW),
        .RATIO     (R),
        .DEPTH     (D),
        .IDLE_PAT  (8'h00)
    ) dut (
        .outclock     (outclock),
        .rst_n        (rst_n),
        .wr           (wr_bus.slave),
        .clr_underrun (clr_underrun),
        .dataout      (dataout),
        .oe           (oe),
        .fill         (fill),
        .underrun     (underrun)
    );

    always #5 outclock = ~outclock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge outclock);
        #1;
    endtask

    // Called 1 ns after a rising edge: high phase now, low phase 5 ns later.
    task automatic check_pair(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                              input logic exp_oe);
        check({tag, "_hi"}, dataout, hi);
        check({tag, "_oe"}, oe, exp_oe);
        #5;
        check({tag, "_lo"}, dataout, lo);
    endtask

    task automatic send(input logic [31:0] w, input logic l);
        bit   done;
        logic r;
        done = 1'b0;
        wr_bus.data  = w;
        wr_bus.last  = l;
        wr_bus.valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            r = wr_bus.ready;
            tick();
            done = r;
        end
        check("send_accepted", done, 1);
        wr_bus.valid = 1'b0;
    endtask

    task automatic send_all;
        for (int i = 0; i < words.size(); i++) begin
            send(words[i], i == words.size() - 1);
        end
    endtask

    task automatic build_expect;
        exp_hi.delete();
        exp_lo.delete();
        foreach (words[i]) begin
            exp_hi.push_back(words[i][7:0]);
            exp_lo.push_back(words[i][15:8]);
            exp_hi.push_back(words[i][23:16]);
            exp_lo.push_back(words[i][31:24]);
        end
    endtask

    // Waits for oe, then requires every expected pair on consecutive cycles.
    task automatic watch(input string tag);
        int waited;
        waited = 0;
        while (oe !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_start"}, oe, 1);
        for (int i = 0; i < exp_hi.size(); i++) begin
            check_pair($sformatf("%s_p%0d", tag, i), exp_hi[i], exp_lo[i], 1'b1);
            tick();
        end
        check({tag, "_end_oe"}, oe, 0);
        check({tag, "_end_idle"}, dataout, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_bus.data  = '0;
        wr_bus.last  = 1'b0;
        wr_bus.valid = 1'b0;

        // Reset state, both clock phases
        #2;
        check("rst_dataout_lo", dataout, 8'h00);
        check("rst_oe", oe, 0);
        check("rst_fill", fill, 0);
        check("rst_ready", wr_bus.ready, 1);
        check("rst_underrun", underrun, 0);
        #5;
        check("rst_dataout_hi", dataout, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();

        // Single burst
        send(32'h44332211, 1'b1);
        check("single_fill1", fill, 1);
        check("single_pre_oe", oe, 0);
        check("single_pre_idle", dataout, 8'h00);
        tick();
        check_pair("single0", 8'h11, 8'h22, 1'b1);
        check("single_fill0", fill, 0);
        tick();
        check_pair("single1", 8'h33, 8'h44, 1'b1);
        tick();
        check("single_end_oe", oe, 0);
        check("single_end_hi", dataout, 8'h00);
        check("single_underrun", underrun, 0);
        #5;
        check("single_end_lo", dataout, 8'h00);
        tick();

        // Back-to-back burst of four words
        words = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0, 32'hD3D2D1D0};
        build_expect();
        fork
            send_all();
            watch("b2b");
        join
        check("b2b_underrun", underrun, 0);
        tick();

        // Fill the FIFO faster than it drains
        words.delete();
        for (int i = 0; i < 10; i++) begin
            words.push_back({8'(8'h40 + i), 8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i)});
        end
        build_expect();
        saw_full = 1'b0;
        fork
            send_all();
            watch("full");
            begin
                for (int c = 0; c < 30; c++) begin
                    tick();
                    if (fill == 3'd4) begin
                        saw_full = 1'b1;
                        check("full_ready_low", wr_bus.ready, 0);
                    end else begin
                        check("full_ready_high", wr_bus.ready, 1);
                    end
                end
            end
        join
        check("full_reached", saw_full, 1);
        check("full_drained", fill, 0);
        check("full_underrun", underrun, 0);
        tick();

        // Underrun: burst without last word
        send(32'h88776655, 1'b0);
        tick();
        check_pair("ur0", 8'h55, 8'h66, 1'b1);
        tick();
        check_pair("ur1", 8'h77, 8'h88, 1'b1);
        tick();
        check("ur_end_oe", oe, 0);
        check("ur_set", underrun, 1);
        tick();
        tick();
        check("ur_sticky", underrun, 1);
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        check("ur_cleared", underrun, 0);

        // Set and clear in the same cycle: set wins
        send(32'h0D0C0B0A, 1'b0);
        tick();
        tick();
        check("ur_pre_set", underrun, 0);
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        check("ur_set_wins", underrun, 1);
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        check("ur_cleared2", underrun, 0);
        tick();

        // Reset during phase 1 of a three-word burst
        send(32'h13121110, 1'b0);
        send(32'h23222120, 1'b0);
        send(32'h33323130, 1'b1);
        check("mid_phase1_hi", dataout, 8'h12);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_oe", oe, 0);
        check("mid_rst_hi", dataout, 8'h00);
        check("mid_rst_fill", fill, 0);
        check("mid_rst_ready", wr_bus.ready, 1);
        #3;
        check("mid_rst_lo", dataout, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_oe", oe, 0);
        check("post_rst_fill", fill, 0);
        send(32'hDDCCBBAA, 1'b1);
        tick();
        check_pair("post0", 8'hAA, 8'hBB, 1'b1);
        tick();
        check_pair("post1", 8'hCC, 8'hDD, 1'b1);
        tick();
        check("post_end_oe", oe, 0);
        check("post_underrun", underrun, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/ddr_tx_gearbox.md
# ddr_tx_gearbox

Parametrised DDR transmit gearbox for the line-side pad ring. Accepts wide words from the core through a valid/ready handshake, buffers them in a small FIFO, and serialises each word into beat pairs driven on the rising (high) and falling (low) half of `outclock`. Adds burst framing, an idle pattern, output-enable and sticky underrun detection. Sits between the framer TX datapath and the pads.

## Interface
- `PAD_WIDTH`, 8: pad bits per beat.
- `RATIO`, 4: beats per input word; even, ≥2.
- `DEPTH`, 4: FIFO depth in words; power of two, ≥2.
- `IDLE_PAT`, 8'h00 (PAD_WIDTH bits): value driven on both halves when idle.

- `outclock`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_data`  in  RATIO*PAD_WIDTH  input word; beat k = bits [k*PAD_WIDTH +: PAD_WIDTH].
- `wr_last`  in  1  word is last of its burst.
- `wr_valid`  in  1  word offered.
- `wr_ready`  out  1  FIFO can accept; transfer on `wr_valid & wr_ready`.
- `clr_underrun`  in  1  clears `underrun`.
- `dataout`  out  PAD_WIDTH  DDR pad data: high-phase beat while `outclock`=1, low-phase beat while 0.
- `oe`  out  1  registered pad output enable, high while bursting.
- `fill`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `underrun`  out  1  sticky underrun flag.

## Operation
- Reset values: `wr_ready`=1, `fill`=0, `oe`=0, `underrun`=0, high/low beat registers = `IDLE_PAT`, state IDLE, phase 0.
- FIFO: stores {`wr_last`, `wr_data`}; write/read pointers wrap modulo DEPTH; `wr_ready` = (`fill` != DEPTH), independent of a same-cycle pop (no full bypass). Writes while full are ignored. No empty bypass: a word written into an empty FIFO is poppable the following cycle. Simultaneous push and pop leave `fill` unchanged.
- Serialiser: phase counter 0..RATIO/2-1. At phase p, high register ← beat 2p, low register ← beat 2p+1 of current word. A word occupies RATIO/2 cycles.
- States:
  - IDLE: beats = `IDLE_PAT`, `oe`=0. If FIFO non-empty: pop, load word, phase 0 → RUN.
  - RUN: `oe`=1, phase advances each cycle. At last phase: if FIFO non-empty, pop next word, phase 0, stay RUN (back-to-back, no gap); else → IDLE; if the current word lacked `wr_last`, set `underrun`.
  - A popped `wr_last` word followed by a non-empty FIFO continues without gap (burst boundaries do not insert idle).
- `underrun` set has priority over `clr_underrun` in the same cycle.
- Reset mid-burst: all state returns to reset values immediately; FIFO contents discarded; `dataout` shows `IDLE_PAT`.

## Timing
- Accept at edge E into empty FIFO in IDLE: pop at E+1; beats 0/1 on `dataout` in the cycle following E+1, `oe`=1 same cycle.
- `oe` and beat registers change on the same edge; pad output delay from the registers is combinational (clock-phase select only).
- Throughput: one word per RATIO/2 cycles sustained when `fill` ≥1 at each word boundary.
- `fill` reflects pushes/pops of the previous edge; `wr_ready` is a registered-count decode, no combinational path from `wr_valid`.

## Structure
- Package `ddr_tx_pkg`: state enumeration (IDLE, RUN), default idle pattern, helper for phase-counter width.
- One sub-module: `ddr_tx_fifo` (DEPTH×(RATIO*PAD_WIDTH+1) storage, pointers, `fill`). Serialiser, state machine and output phase select stay in the top.

## Test plan
- Single burst, PAD_WIDTH=8, RATIO=4: write 32'h44332211 with `wr_last`=1 into idle block → cycle N: high=11/low=22, N+1: 33/44, then IDLE_PAT, `oe` high exactly 2 cycles, `underrun`=0.
- Back-to-back: 4 words written continuously, last flagged → 8 consecutive cycles of beats in order, no idle gap, `oe` continuous.
- Full: hold output stalled by writing DEPTH+1 words in consecutive cycles from IDLE at reset → `wr_ready` drops when `fill`=4; excess write not accepted; all accepted words emitted in order.
- Underrun: write one word with `wr_last`=0 then nothing → burst ends after 2 cycles, `underrun`=1 and stays; pulse `clr_underrun` → 0; set and clear same cycle → stays 1.
- Reset mid-burst: assert `rst_n`=0 during phase 1 of a 3-word burst → `oe`=0, `dataout`=IDLE_PAT, `fill`=0 immediately; after release, new word emitted normally.
